// File: rtl/hazard_forwarding_unit_if.sv
// Pipeline-side signal bundle for the hazard/forwarding controller.
// The pipeline drives the stage fields (master); the controller returns selects and stall (slave).
interface hazard_forwarding_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              fwd_en;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_rs_used;
    logic              id_rt_used;
    logic              id_is_mul;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic              ex_is_mul;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_reg_write;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_reg_write;
    logic [1:0]        forward_rs;
    logic [1:0]        forward_rt;
    logic              stall;
    logic              bubble;
    logic              mul_busy;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output fwd_en, id_rs, id_rt, id_rs_used, id_rt_used, id_is_mul,
               ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        input  forward_rs, forward_rt, stall, bubble, mul_busy, stall_count
    );

    modport slave (
        input  fwd_en, id_rs, id_rt, id_rs_used, id_rt_used, id_is_mul,
               ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_is_mul,
               mem_rd, mem_reg_write, wb_rd, wb_reg_write,
        output forward_rs, forward_rt, stall, bubble, mul_busy, stall_count
    );
endinterface

// File: rtl/hazard_forwarding_unit.sv
// EX operand forwarding and ID RAW/structural hazard detection for the 5-stage pipeline,
// with a single-entry multiplier pending-write scoreboard and a saturating stall counter.
module hazard_forwarding_unit #(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    arst,
    hazard_forwarding_unit_if.slave hz
);
    localparam logic [3:0] LAT = 4'(MUL_LAT);

    logic              pend_valid;
    logic [REG_AW-1:0] pend_rd;
    logic [3:0]        pend_cnt;
    logic [CNT_W-1:0]  stall_count_q;

    logic dep_ex, dep_mem, dep_pend;
    logic load_use, mul_issue, sb_hit, structural, no_fwd;
    logic stall_raw, issue;

    function automatic logic match(input logic used,
                                   input logic [REG_AW-1:0] s,
                                   input logic [REG_AW-1:0] d);
        return used && (s != '0) && (s == d);
    endfunction

    // MEM is the younger result, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic              en,
                                           input logic [REG_AW-1:0] src,
                                           input logic              mem_w,
                                           input logic [REG_AW-1:0] mem_d,
                                           input logic              wb_w,
                                           input logic [REG_AW-1:0] wb_d);
        if (en && mem_w && (mem_d != '0) && (src == mem_d)) return 2'b11;
        if (en && wb_w && (wb_d != '0) && (src == wb_d))    return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        dep_ex   = match(hz.id_rs_used, hz.id_rs, hz.ex_rd)   | match(hz.id_rt_used, hz.id_rt, hz.ex_rd);
        dep_mem  = match(hz.id_rs_used, hz.id_rs, hz.mem_rd)  | match(hz.id_rt_used, hz.id_rt, hz.mem_rd);
        dep_pend = match(hz.id_rs_used, hz.id_rs, pend_rd)    | match(hz.id_rt_used, hz.id_rt, pend_rd);

        load_use   = hz.ex_mem_read & hz.ex_reg_write & dep_ex;
        mul_issue  = hz.ex_is_mul & hz.ex_reg_write & dep_ex;
        sb_hit     = pend_valid & dep_pend;
        structural = hz.id_is_mul & (pend_valid | hz.ex_is_mul);
        // Without forwarding, any in-flight writer in EX or MEM must drain; WB is covered by the write-first regfile.
        no_fwd     = ~hz.fwd_en & ((hz.ex_reg_write & dep_ex) | (hz.mem_reg_write & dep_mem));

        stall_raw  = load_use | mul_issue | sb_hit | structural | no_fwd;
        issue      = hz.ex_is_mul & hz.ex_reg_write & (hz.ex_rd != '0);
    end

    assign hz.forward_rs = arst ? 2'b00 :
        fwd_sel(hz.fwd_en, hz.ex_rs, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
    assign hz.forward_rt = arst ? 2'b00 :
        fwd_sel(hz.fwd_en, hz.ex_rt, hz.mem_reg_write, hz.mem_rd, hz.wb_reg_write, hz.wb_rd);
    assign hz.stall       = stall_raw & ~arst;
    assign hz.bubble      = stall_raw & ~arst;
    assign hz.mul_busy    = pend_valid & ~arst;
    assign hz.stall_count = stall_count_q;

    // The entry covers exactly MUL_LAT cycles after issue; a later issue overwrites it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            pend_valid    <= 1'b0;
            pend_rd       <= '0;
            pend_cnt      <= 4'd0;
            stall_count_q <= '0;
        end else begin
            if (issue) begin
                pend_valid <= 1'b1;
                pend_rd    <= hz.ex_rd;
                pend_cnt   <= LAT;
            end else if (pend_valid) begin
                pend_cnt <= pend_cnt - 4'd1;
                if (pend_cnt == 4'd1) pend_valid <= 1'b0;
            end
            if (stall_raw && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Directed bench for hazard_forwarding_unit: forwarding priority, hazards, scoreboard timing,
// reset behaviour, and counter saturation on a second narrow-counter instance.
module tb_hazard_forwarding_unit;
    logic clk = 1'b0;
    logic arst;
    int   checks   = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    hazard_forwarding_unit_if #(.REG_AW(5), .CNT_W(16)) bus ();
    hazard_forwarding_unit_if #(.REG_AW(5), .CNT_W(3))  sat_bus ();

    hazard_forwarding_unit #(.REG_AW(5), .MUL_LAT(4), .CNT_W(16)) dut (
        .clk (clk),
        .arst(arst),
        .hz  (bus.slave)
    );

    hazard_forwarding_unit #(.REG_AW(5), .MUL_LAT(4), .CNT_W(3)) dut_sat (
        .clk (clk),
        .arst(arst),
        .hz  (sat_bus.slave)
    );

    assign sat_bus.fwd_en        = bus.fwd_en;
    assign sat_bus.id_rs         = bus.id_rs;
    assign sat_bus.id_rt         = bus.id_rt;
    assign sat_bus.id_rs_used    = bus.id_rs_used;
    assign sat_bus.id_rt_used    = bus.id_rt_used;
    assign sat_bus.id_is_mul     = bus.id_is_mul;
    assign sat_bus.ex_rs         = bus.ex_rs;
    assign sat_bus.ex_rt         = bus.ex_rt;
    assign sat_bus.ex_rd         = bus.ex_rd;
    assign sat_bus.ex_reg_write  = bus.ex_reg_write;
    assign sat_bus.ex_mem_read   = bus.ex_mem_read;
    assign sat_bus.ex_is_mul     = bus.ex_is_mul;
    assign sat_bus.mem_rd        = bus.mem_rd;
    assign sat_bus.mem_reg_write = bus.mem_reg_write;
    assign sat_bus.wb_rd         = bus.wb_rd;
    assign sat_bus.wb_reg_write  = bus.wb_reg_write;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.fwd_en        = 1'b1;
        bus.id_rs         = '0;
        bus.id_rt         = '0;
        bus.id_rs_used    = 1'b0;
        bus.id_rt_used    = 1'b0;
        bus.id_is_mul     = 1'b0;
        bus.ex_rs         = '0;
        bus.ex_rt         = '0;
        bus.ex_rd         = '0;
        bus.ex_reg_write  = 1'b0;
        bus.ex_mem_read   = 1'b0;
        bus.ex_is_mul     = 1'b0;
        bus.mem_rd        = '0;
        bus.mem_reg_write = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_reg_write  = 1'b0;
    endtask

    task automatic clear_ex();
        bus.ex_is_mul    = 1'b0;
        bus.ex_reg_write = 1'b0;
        bus.ex_mem_read  = 1'b0;
        bus.ex_rd        = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic pulse_reset();
        arst = 1'b1;
        #1;
        arst = 1'b0;
        #1;
    endtask

    initial begin
        // Reset: outputs forced low even with hazard/forward-worthy inputs present
        arst = 1'b1;
        idle();
        bus.ex_rs = 5'd3; bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1;
        bus.id_rs = 5'd3; bus.id_rs_used = 1'b1;
        bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1; bus.ex_mem_read = 1'b1;
        #2;
        check("rst_forward_rs", 32'(bus.forward_rs), 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_bubble", 32'(bus.bubble), 32'd0);
        check("rst_mul_busy", 32'(bus.mul_busy), 32'd0);
        check("rst_stall_count", 32'(bus.stall_count), 32'd0);
        next_cycle();
        next_cycle();
        idle();
        arst = 1'b0;
        settle();

        // Forwarding priority
        bus.ex_rs = 5'd3; bus.mem_rd = 5'd3; bus.mem_reg_write = 1'b1;
        bus.wb_rd = 5'd3; bus.wb_reg_write = 1'b1;
        settle();
        check("fwd_mem_wins", 32'(bus.forward_rs), 32'd3);
        bus.mem_reg_write = 1'b0;
        settle();
        check("fwd_wb", 32'(bus.forward_rs), 32'd2);
        bus.ex_rs = 5'd0; bus.wb_rd = 5'd0;
        settle();
        check("fwd_r0", 32'(bus.forward_rs), 32'd0);
        bus.ex_rt = 5'd3; bus.wb_rd = 5'd3;
        settle();
        check("fwd_rt_wb", 32'(bus.forward_rt), 32'd2);
        bus.fwd_en = 1'b0;
        settle();
        check("fwd_disabled", 32'(bus.forward_rt), 32'd0);
        check("fwd_no_stall", 32'(bus.stall), 32'd0);
        idle();
        next_cycle();

        // Load-use
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rt = 5'd5; bus.id_rt_used = 1'b0;
        settle();
        check("lu_unused", 32'(bus.stall), 32'd0);
        bus.id_rt_used = 1'b1;
        settle();
        check("lu_stall", 32'(bus.stall), 32'd1);
        check("lu_bubble", 32'(bus.bubble), 32'd1);
        next_cycle();
        clear_ex();
        bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b1;
        settle();
        check("lu_release", 32'(bus.stall), 32'd0);
        check("lu_count", 32'(bus.stall_count), 32'd1);
        bus.ex_rt = 5'd5;
        settle();
        check("lu_fwd_mem", 32'(bus.forward_rt), 32'd3);
        idle();
        next_cycle();

        // Stall-only mode
        bus.fwd_en = 1'b0; bus.mem_rd = 5'd9; bus.mem_reg_write = 1'b1;
        bus.id_rs = 5'd9; bus.id_rs_used = 1'b1; bus.ex_rs = 5'd9;
        settle();
        check("nofwd_mem_stall", 32'(bus.stall), 32'd1);
        check("nofwd_sel", 32'(bus.forward_rs), 32'd0);
        bus.fwd_en = 1'b1;
        settle();
        check("fwd_mem_nostall", 32'(bus.stall), 32'd0);
        check("fwd_mem_sel", 32'(bus.forward_rs), 32'd3);
        bus.fwd_en = 1'b0; bus.mem_reg_write = 1'b0;
        bus.wb_rd = 5'd9; bus.wb_reg_write = 1'b1;
        settle();
        check("nofwd_wb_nostall", 32'(bus.stall), 32'd0);
        bus.ex_rd = 5'd4; bus.ex_reg_write = 1'b1; bus.id_rt = 5'd4; bus.id_rt_used = 1'b1;
        settle();
        check("nofwd_ex_stall", 32'(bus.stall), 32'd1);
        bus.fwd_en = 1'b1;
        settle();
        check("fwd_alu_nostall", 32'(bus.stall), 32'd0);
        idle();
        bus.fwd_en = 1'b0; bus.mem_rd = 5'd0; bus.mem_reg_write = 1'b1;
        bus.id_rs = 5'd0; bus.id_rs_used = 1'b1;
        settle();
        check("nofwd_r0", 32'(bus.stall), 32'd0);
        idle();

        // Multiplier dependency
        next_cycle();
        pulse_reset();
        bus.ex_is_mul = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs = 5'd7; bus.id_rs_used = 1'b1;
        settle();
        check("mul_issue_stall", 32'(bus.stall), 32'd1);
        check("mul_issue_busy", 32'(bus.mul_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            clear_ex();
            settle();
            check("mul_dep_stall", 32'(bus.stall), 32'd1);
            check("mul_dep_busy", 32'(bus.mul_busy), 32'd1);
        end
        next_cycle();
        settle();
        check("mul_done_stall", 32'(bus.stall), 32'd0);
        check("mul_done_busy", 32'(bus.mul_busy), 32'd0);
        check("mul_count", 32'(bus.stall_count), 32'd5);

        // Structural
        idle();
        bus.ex_is_mul = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd8;
        bus.id_rs = 5'd2; bus.id_rs_used = 1'b1;
        settle();
        check("struct_indep", 32'(bus.stall), 32'd0);
        bus.id_is_mul = 1'b1;
        settle();
        check("struct_ex_mul", 32'(bus.stall), 32'd1);
        bus.id_is_mul = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            clear_ex();
            bus.id_is_mul = 1'b1;
            settle();
            check("struct_stall", 32'(bus.stall), 32'd1);
        end
        next_cycle();
        settle();
        check("struct_release", 32'(bus.stall), 32'd0);
        check("struct_busy_low", 32'(bus.mul_busy), 32'd0);
        check("struct_count", 32'(bus.stall_count), 32'd9);

        // Reset mid-multiply
        idle();
        bus.ex_is_mul = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd6;
        next_cycle();
        clear_ex();
        next_cycle();
        bus.id_rs = 5'd6; bus.id_rs_used = 1'b1;
        settle();
        check("rmid_stall", 32'(bus.stall), 32'd1);
        arst = 1'b1;
        settle();
        check("rmid_busy", 32'(bus.mul_busy), 32'd0);
        check("rmid_stall_rst", 32'(bus.stall), 32'd0);
        check("rmid_count", 32'(bus.stall_count), 32'd0);
        arst = 1'b0;
        settle();
        check("rmid_post_stall", 32'(bus.stall), 32'd0);
        check("rmid_post_busy", 32'(bus.mul_busy), 32'd0);
        next_cycle();
        check("rmid_post_count", 32'(bus.stall_count), 32'd0);

        // Saturation on the 3-bit counter instance
        idle();
        pulse_reset();
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5;
        bus.id_rt = 5'd5; bus.id_rt_used = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            settle();
            check("sat_count", 32'(sat_bus.stall_count), (i > 7) ? 32'd7 : 32'(i));
        end
        check("sat_stall", 32'(sat_bus.stall), 32'd1);
        check("wide_count", 32'(bus.stall_count), 32'd10);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
